sdf_stage_4: RTL and testbench

SDF_STAGE_4 -- requirements
Module: sdf_stage_4

---
 rtl/sdf_stage_4.sv | 146 ++++++++++++++
 tb/tb_sdf_stage_4.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdf_stage_4.sv
// sdf_stage_4 -- radix-2 single-path delay-feedback FFT stage with a
// 4-entry complex delay line and Q16.8 arithmetic.
// Optional build macro: SDF4_ROUND_EN. When it is defined, the twiddle
// multiply rounds half up. When it is not defined, the multiply truncates.
// The phase input (fill / pass / butterfly) comes from an external
// twiddle sequencer and is sampled together with the data.
module sdf_stage_4 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [23:0] din_r,
    input  logic [23:0] din_i,
    input  logic [1:0]  state,
    input  logic [23:0] w_r,
    input  logic [23:0] w_i,
    output logic        out_valid,
    output logic [23:0] dout_r,
    output logic [23:0] dout_i
);
    localparam int W     = 24;
    localparam int DEPTH = 4;

`ifdef SDF4_ROUND_EN
    localparam logic signed [2*W:0] ROUND_BIAS = 49'sd128;
`else
    localparam logic signed [2*W:0] ROUND_BIAS = '0;
`endif

    typedef enum logic [1:0] {
        PH_FILL = 2'd0,
        PH_PASS = 2'd1,
        PH_BFLY = 2'd2,
        PH_IDLE = 2'd3
    } phase_t;

    phase_t w_phase;

    // Delay line: entry 0 is the newest sample, entry DEPTH-1 is the head.
    logic [W-1:0] r_buf_r [DEPTH];
    logic [W-1:0] r_buf_i [DEPTH];
    logic [W-1:0] w_buf_r_next [DEPTH];
    logic [W-1:0] w_buf_i_next [DEPTH];

    logic         w_advance;
    logic [W-1:0] w_x_r, w_x_i;
    logic [W-1:0] w_head_r, w_head_i;
    logic [W-1:0] w_sum_r, w_sum_i;
    logic [W-1:0] w_dif_r, w_dif_i;

    logic signed [2*W-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
    logic signed [2*W:0]   w_acc_re, w_acc_im;
    logic [W-1:0]          w_mul_r, w_mul_i;
    logic [W-1:0]          w_new_r, w_new_i;
    logic                  w_unused_bits;

    assign w_phase = phase_t'(state);

    // The pass and butterfly phases always advance. A gap in those phases
    // is treated as a zero sample. The fill phase advances only on a real sample.
    assign w_advance = ((w_phase == PH_FILL) && in_valid)
                     || (w_phase == PH_PASS)
                     || (w_phase == PH_BFLY);

    assign w_x_r = in_valid ? din_r : '0;
    assign w_x_i = in_valid ? din_i : '0;

    assign w_head_r = r_buf_r[DEPTH-1];
    assign w_head_i = r_buf_i[DEPTH-1];

    // Butterfly add/subtract, wrapping modulo 2^24
    assign w_sum_r = w_head_r + w_x_r;
    assign w_sum_i = w_head_i + w_x_i;
    assign w_dif_r = w_head_r - w_x_r;
    assign w_dif_i = w_head_i - w_x_i;

    // Twiddle multiply: full-precision products, 49-bit sums, then >>> 8
    assign w_p_rr = $signed(w_dif_r) * $signed(w_r);
    assign w_p_ii = $signed(w_dif_i) * $signed(w_i);
    assign w_p_ri = $signed(w_dif_r) * $signed(w_i);
    assign w_p_ir = $signed(w_dif_i) * $signed(w_r);

    assign w_acc_re = $signed({w_p_rr[2*W-1], w_p_rr})
                    - $signed({w_p_ii[2*W-1], w_p_ii}) + ROUND_BIAS;
    assign w_acc_im = $signed({w_p_ri[2*W-1], w_p_ri})
                    + $signed({w_p_ir[2*W-1], w_p_ir}) + ROUND_BIAS;

    // Bits [31:8] of the sum are the low 24 bits of (sum >>> 8)
    assign w_mul_r = w_acc_re[W+7:8];
    assign w_mul_i = w_acc_im[W+7:8];

    // The fraction bits and the high bits drop out of the Q16.8 result
    assign w_unused_bits = ^{w_acc_re[2*W:W+8], w_acc_re[7:0],
                             w_acc_im[2*W:W+8], w_acc_im[7:0]};

    // The butterfly phase feeds back the twiddled difference. The other phases store din.
    assign w_new_r = (w_phase == PH_BFLY) ? w_mul_r : w_x_r;
    assign w_new_i = (w_phase == PH_BFLY) ? w_mul_i : w_x_i;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_shift
            if (gi == 0) begin : g_in
                assign w_buf_r_next[gi] = w_new_r;
                assign w_buf_i_next[gi] = w_new_i;
            end else begin : g_mid
                assign w_buf_r_next[gi] = r_buf_r[gi-1];
                assign w_buf_i_next[gi] = r_buf_i[gi-1];
            end
        end
    endgenerate

    // Delay line: shift by one entry on every advance, clear on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_r[i] <= '0;
                r_buf_i[i] <= '0;
            end
        end else if (w_advance) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_r[i] <= w_buf_r_next[i];
                r_buf_i[i] <= w_buf_i_next[i];
            end
        end
    end

    // Output register: butterfly sum or pass-through head; otherwise hold dout
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            dout_r    <= '0;
            dout_i    <= '0;
        end else if (w_advance && (w_phase == PH_BFLY)) begin
            out_valid <= 1'b1;
            dout_r    <= w_sum_r;
            dout_i    <= w_sum_i;
        end else if (w_advance && (w_phase == PH_PASS)) begin
            out_valid <= 1'b1;
            dout_r    <= w_head_r;
            dout_i    <= w_head_i;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdf_stage_4.sv
// tb_sdf_stage_4 -- self-checking bench for sdf_stage_4. A queue-based
// reference model of the delay line supplies the expected values.
// Build with +define+SDF4_ROUND_EN to check the rounding variant.
module tb_sdf_stage_4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [23:0] din_r = '0, din_i = '0;
    logic [1:0]  state = 2'd0;
    logic [23:0] w_r = '0, w_i = '0;
    logic        out_valid;
    logic [23:0] dout_r, dout_i;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    // Reference model: queue front = newest, queue back = head
    int q_r[$];
    int q_i[$];
    bit m_ov;
    int m_dr, m_di;

    sdf_stage_4 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .din_r(din_r), .din_i(din_i), .state(state),
        .w_r(w_r), .w_i(w_i),
        .out_valid(out_valid), .dout_r(dout_r), .dout_i(dout_i)
    );

    always #5 clk = ~clk;

    function automatic int wrap24(longint v);
        logic [23:0] t;
        t = v[23:0];
        return int'($signed(t));
    endfunction

    // Q16.8 product scaling: floor(s / 256), or floor((s + 128) / 256) when rounding
    function automatic int scale(longint s);
        longint t;
        t = s;
`ifdef SDF4_ROUND_EN
        t = t + 128;
`endif
        return wrap24(t >>> 8);
    endfunction

    function automatic int rnd24();
        return wrap24(longint'($urandom));
    endfunction

    task automatic model_push(input int vr, input int vi);
        q_r = {vr, q_r[0:2]};
        q_i = {vi, q_i[0:2]};
    endtask

    // Apply one cycle of stimulus, advance the model, and sample the DUT 1 ns after the edge
    task automatic step(input bit r, input bit iv, input int st,
                        input int dr, input int di, input int wr, input int wi);
        int  xr, xi, hr, hi, er, ei, tr, ti;
        bit  adv;
        rst = r; in_valid = iv; state = st[1:0];
        din_r = dr[23:0]; din_i = di[23:0]; w_r = wr[23:0]; w_i = wi[23:0];
        xr = iv ? wrap24(dr) : 0;
        xi = iv ? wrap24(di) : 0;
        tr = wrap24(wr);
        ti = wrap24(wi);
        if (r) begin
            q_r = '{0, 0, 0, 0};
            q_i = '{0, 0, 0, 0};
            m_ov = 0; m_dr = 0; m_di = 0;
        end else begin
            adv = (st == 0 && iv) || st == 1 || st == 2;
            m_ov = 0;
            if (adv) begin
                hr = q_r[3];
                hi = q_i[3];
                if (st == 0) begin
                    model_push(xr, xi);
                end else if (st == 1) begin
                    m_ov = 1; m_dr = hr; m_di = hi;
                    model_push(xr, xi);
                end else begin
                    m_ov = 1;
                    m_dr = wrap24(longint'(hr) + xr);
                    m_di = wrap24(longint'(hi) + xi);
                    er = wrap24(longint'(hr) - xr);
                    ei = wrap24(longint'(hi) - xi);
                    model_push(scale(longint'(er) * tr - longint'(ei) * ti),
                               scale(longint'(er) * ti + longint'(ei) * tr));
                end
            end
        end
        @(posedge clk);
        #1;
        txn++;
        $display("txn %0d rst=%0b st=%0d iv=%0b din=(%0d,%0d) w=(%0d,%0d) -> ov=%0b dout=(%0d,%0d)",
                 txn, r, st, iv, xr, xi, tr, ti, out_valid,
                 $signed(dout_r), $signed(dout_i));
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            step(1, 1, 2, rnd24(), rnd24(), rnd24(), rnd24());
            total++;
            if (out_valid !== 1'b0 || dout_r !== 24'd0 || dout_i !== 24'd0) begin
                bad++;
                $display("FAIL reset_out: got ov=%0b dout=(%0d,%0d) want ov=0 dout=(0,0)",
                         out_valid, $signed(dout_r), $signed(dout_i));
            end
        end
        // The delay line must be empty, so draining it yields zeros
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 0, 0, 0, 0);
            total++;
            if (out_valid !== 1'b1 || dout_r !== 24'd0 || dout_i !== 24'd0) begin
                bad++;
                $display("FAIL reset_line[%0d]: got ov=%0b dout=(%0d,%0d) want ov=1 dout=(0,0)",
                         k, out_valid, $signed(dout_r), $signed(dout_i));
            end
        end
    endtask

    task automatic test_fill_butterfly();
        int exp_r[4];
        exp_r = '{512, 768, 1024, -256};
        for (int k = 1; k <= 4; k++) begin
            step(0, 1, 0, 256 * k, 0, 0, 0);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL fill_valid[%0d]: got ov=%0b want 0", k, out_valid);
            end
        end
        step(0, 1, 2, 512, 0, 256, 0);
        total++;
        if (out_valid !== 1'b1 || dout_r !== 24'd768 || dout_i !== 24'd0) begin
            bad++;
            $display("FAIL bfly_w1: got ov=%0b dout=(%0d,%0d) want ov=1 dout=(768,0)",
                     out_valid, $signed(dout_r), $signed(dout_i));
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 0, 0, 0, 0);
            total++;
            if (out_valid !== 1'b1 || dout_r !== 24'(exp_r[k]) || dout_i !== 24'd0) begin
                bad++;
                $display("FAIL bfly_drain[%0d]: got ov=%0b dout=(%0d,%0d) want ov=1 dout=(%0d,0)",
                         k, out_valid, $signed(dout_r), $signed(dout_i), exp_r[k]);
            end
        end
    endtask

    task automatic test_twiddle();
        int er[4], ei[4];
`ifdef SDF4_ROUND_EN
        er = '{0, 0, 180, 0};   ei = '{0, 0, -180, -256};
`else
        er = '{0, 0, 180, 0};   ei = '{0, 0, -181, -256};
`endif
        step(0, 1, 0, 255, 0, 0, 0);
        step(0, 1, 0, 256, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 2, 0, 0, 181, -181);
        total++;
        if (out_valid !== 1'b1 || dout_r !== 24'd255 || dout_i !== 24'd0) begin
            bad++;
            $display("FAIL twiddle_sum: got dout=(%0d,%0d) want (255,0)",
                     $signed(dout_r), $signed(dout_i));
        end
        step(0, 1, 2, 0, 0, 0, -256);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 0, 0, 0, 0);
            total++;
            if (dout_r !== 24'(er[k]) || dout_i !== 24'(ei[k]) ||
                dout_r !== 24'(m_dr) || dout_i !== 24'(m_di)) begin
                bad++;
                $display("FAIL twiddle_store[%0d]: got (%0d,%0d) want (%0d,%0d) model (%0d,%0d)",
                         k, $signed(dout_r), $signed(dout_i), er[k], ei[k], m_dr, m_di);
            end
        end
    endtask

    task automatic test_wrap_gaps();
        int er[4];
        er = '{0, 0, 8388606, 0};
        step(0, 1, 0, 8388607, 0, 0, 0);
        step(0, 1, 0, 5, 7, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 2, 1, 0, 256, 0);
        total++;
        if (out_valid !== 1'b1 || dout_r !== 24'h800000 || dout_i !== 24'd0) begin
            bad++;
            $display("FAIL wrap_add: got dout=(%0d,%0d) want (-8388608,0)",
                     $signed(dout_r), $signed(dout_i));
        end
        // A gap in state 1: din lines carry junk, yet zero must be stored
        step(0, 0, 1, 999, -999, 0, 0);
        total++;
        if (out_valid !== 1'b1 || dout_r !== 24'd5 || dout_i !== 24'd7) begin
            bad++;
            $display("FAIL gap_pass: got ov=%0b dout=(%0d,%0d) want ov=1 dout=(5,7)",
                     out_valid, $signed(dout_r), $signed(dout_i));
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 0, 0, 0, 0);
            total++;
            if (dout_r !== 24'(er[k]) || dout_i !== 24'd0) begin
                bad++;
                $display("FAIL gap_drain[%0d]: got (%0d,%0d) want (%0d,0)",
                         k, $signed(dout_r), $signed(dout_i), er[k]);
            end
        end
        // With no advance, dout holds its value and out_valid drops
        step(0, 0, 0, 0, 0, 0, 0);
        total++;
        if (out_valid !== 1'b0 || dout_r !== 24'd0 || dout_i !== 24'd0) begin
            bad++;
            $display("FAIL hold_idle: got ov=%0b dout=(%0d,%0d) want ov=0 dout=(0,0)",
                     out_valid, $signed(dout_r), $signed(dout_i));
        end
    endtask

    task automatic test_reset_midframe();
        for (int k = 0; k < 4; k++) step(0, 1, 0, rnd24(), rnd24(), 0, 0);
        step(0, 1, 2, rnd24(), rnd24(), 256, 0);
        step(1, 1, 2, rnd24(), rnd24(), 256, 0);
        total++;
        if (out_valid !== 1'b0 || dout_r !== 24'd0 || dout_i !== 24'd0) begin
            bad++;
            $display("FAIL midreset_out: got ov=%0b dout=(%0d,%0d) want ov=0 dout=(0,0)",
                     out_valid, $signed(dout_r), $signed(dout_i));
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 1, 0, 0, 0, 0);
            total++;
            if (out_valid !== 1'b1 || dout_r !== 24'd0 || dout_i !== 24'd0) begin
                bad++;
                $display("FAIL midreset_drain[%0d]: got ov=%0b dout=(%0d,%0d) want ov=1 dout=(0,0)",
                         k, out_valid, $signed(dout_r), $signed(dout_i));
            end
        end
    endtask

    task automatic test_random();
        int st, wr, wi;
        bit r, iv;
        for (int k = 0; k < 300; k++) begin
            r  = ($urandom_range(0, 49) == 0);
            iv = ($urandom_range(0, 3) != 0);
            st = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                wr = int'($urandom_range(0, 512)) - 256;
                wi = int'($urandom_range(0, 512)) - 256;
            end else begin
                wr = rnd24();
                wi = rnd24();
            end
            step(r, iv, st, rnd24(), rnd24(), wr, wi);
            total++;
            if (out_valid !== m_ov || dout_r !== 24'(m_dr) || dout_i !== 24'(m_di)) begin
                bad++;
                $display("FAIL random[%0d]: got ov=%0b dout=(%0d,%0d) want ov=%0b dout=(%0d,%0d)",
                         k, out_valid, $signed(dout_r), $signed(dout_i), m_ov, m_dr, m_di);
            end
        end
    endtask

    initial begin
        q_r = '{0, 0, 0, 0};
        q_i = '{0, 0, 0, 0};
        m_ov = 0; m_dr = 0; m_di = 0;
        test_reset();
        test_fill_butterfly();
        test_twiddle();
        test_wrap_gaps();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
